fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain stage of the asynchronous FIFO, in the rclk domain directly downstream of the read pointer/empty logic. It watches `rempty` and issues `rinc` pops. It captures the synchronous-read memory output one cycle after each pop. It presents the words in FIFO order on a valid/ready stream through a 2-entry output buffer, sustaining one word per cycle under continuous `out_ready`.

## Interface
- DATASIZE, 8: width of a FIFO word.
- rclk  in  1  read-domain clock; all state on rising edge.
- r_rst  in  1  reset, synchronous, active-high.
- rempty  in  1  registered empty flag from the read pointer block.
- rinc  out  1  pop request to the read pointer block; combinational.
- rdata  in  DATASIZE  memory read data; valid in the cycle after a pop.
- out_valid  out  1  output word available; registered.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATASIZE  head-of-buffer word; registered.
- rlevel  out  2  words held in the output buffer, 0..2.

## Operation
- Pop definition: a pop occurs in any cycle with `rinc=1 && rempty=0`.
- `inflight` is a 1-bit register set for the cycle following each pop.
- `rinc = !r_rst && !rempty && (count + inflight - (out_valid && out_ready)) < 2`.
  - Evaluate at 3-bit width.
  - The buffer can never be oversubscribed.
- Landing: when `inflight=1`, `rdata` is written into the buffer tail at the clock edge.
- Consume: when `out_valid && out_ready`, the head is retired at the clock edge.
- Landing and consume in the same cycle: `count` is unchanged, head and tail both advance, and order is preserved.
- The buffer is a 2-entry circular store with 1-bit head and tail pointers and a 2-bit `count`.
  - `out_valid = (count != 0)`.
  - `out_data = entry[head]`.
  - `rlevel = count`.
- Stall rule: while `out_valid && !out_ready`, `out_data` is held stable.
- Overflow impossible by the `rinc` rule; an assertion flags landing when `count==2` without a consume.
- Underflow impossible: a consume requires `out_valid`.
- Empty FIFO: `rinc` stays 0 and no spurious words appear.
- Reset, including mid-operation: at the first edge with `r_rst=1`:
  - count, head, tail and inflight go to 0, and an in-flight word is discarded.
  - `out_valid=0`, `rlevel=0`, `out_data=0`.
  - `rinc` is forced to 0 while `r_rst` is high.
  - The read pointer block resets in the same domain, so no data is orphaned.

## Timing
- First-word latency: `rempty` low in cycle N gives `rinc=1` in N, `rdata` valid in N+1, and `out_valid=1` from N+2.
- Throughput: 1 word/cycle with a non-empty FIFO and `out_ready` held high.
- Backpressure: `out_ready` low for ≥2 cycles fills the buffer, then `rinc=0`. On release, `out_valid` does not drop between the buffered words and the refill.
- `rinc` depends combinationally on `rempty`, `out_ready` and registered state. There is no combinational path from `rdata` to any output.

## Structure
- Shared package `fifo_pkg` holds:
  - `DATASIZE`/`ADDRSIZE` defaults.
  - `typedef logic [DATASIZE-1:0] fifo_word_t`.
  - The `OUTBUF_DEPTH=2` constant.
- One sub-module is natural: `fifo_out_buf`, the 2-entry circular buffer with push/pop/count. The top level holds the `inflight` register and the `rinc` credit logic.

## Test plan
- Reset, then `rempty=1` for 10 cycles -> `rinc`, `out_valid` and `rlevel` are 0 throughout.
- Load words 0xA1,0xA2,0xA3 with `out_ready=1` -> `out_valid` rises 2 cycles after `rempty` falls, then 0xA1,0xA2,0xA3 appear on consecutive cycles.
- 8 words queued and `out_ready=0` -> exactly 2 pops, `rlevel=2`, `rinc=0`, and `out_data=0x01` held stable. Then `out_ready=1` -> all 8 words arrive in order with no bubble.
- `out_ready` toggling 1,0,1,0 on a continuous stream -> no loss or duplication; the sequence 0x10..0x1F is received intact.
- Assert `r_rst` in the cycle after a pop (inflight=1, `rlevel=1`) -> the next cycle shows `out_valid=0`, `rlevel=0`, `rinc=0`, and the discarded word never appears.
- FIFO holding exactly 1 word while consuming every cycle -> a single pop, then `rinc` stays 0 with `rempty=1`, and one output word only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the asynchronous FIFO read side.
package fifo_pkg;
    localparam int DATASIZE     = 8;
    localparam int ADDRSIZE     = 4;
    localparam int OUTBUF_DEPTH = 2;

    typedef logic [DATASIZE-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry circular output buffer: push at tail, pop at head, level count.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DW = DATASIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head_data
);
    logic [DW-1:0] mem_q [OUTBUF_DEPTH];
    logic [DW-1:0] mem_d [OUTBUF_DEPTH];
    logic          head_q, head_d;
    logic          tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          pop_ok;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
        end
        if (pop_ok) begin
            head_d = ~head_q;
        end
        // Simultaneous push and pop leaves the level unchanged.
        count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain: pops the FIFO, lands read data one cycle later, and
// streams words out through a 2-entry buffer with credit-based popping.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATASIZE = fifo_pkg::DATASIZE
) (
    input  logic                rclk,
    input  logic                r_rst,
    input  logic                rempty,
    output logic                rinc,
    input  logic [DATASIZE-1:0] rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATASIZE-1:0] out_data,
    output logic [1:0]          rlevel
);
    logic       inflight_q, inflight_d;
    logic [1:0] count;
    logic       consume;
    logic [2:0] credit;

    assign out_valid = (count != 2'd0);
    assign consume   = out_valid && out_ready;
    assign rlevel    = count;

    // Words held plus the word in flight, less the one leaving this cycle.
    always_comb begin
        credit = {1'b0, count} + {2'b00, inflight_q} - {2'b00, consume};
        rinc   = !r_rst && !rempty && (credit < 3'd2);
    end

    always_comb begin
        inflight_d = rinc && !rempty;
    end

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_out_buf #(
        .DW(DATASIZE)
    ) u_out_buf (
        .clk      (rclk),
        .rst      (r_rst),
        .push     (inflight_q),
        .push_data(rdata),
        .pop      (consume),
        .count    (count),
        .head_data(out_data)
    );

    a_no_overflow: assert property (
        @(posedge rclk) disable iff (r_rst)
        !(inflight_q && count == 2'd2 && !consume)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed testbench for fifo_rd_stream with a simple FIFO memory model.
module tb_fifo_rd_stream;
    logic       clk = 1'b0;
    logic       r_rst;
    logic       rempty;
    logic       rinc;
    logic [7:0] rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] rlevel;

    int errors = 0;
    int checks = 0;

    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    logic [7:0] rx [$];

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATASIZE(8)) dut (
        .rclk     (clk),
        .r_rst    (r_rst),
        .rempty   (rempty),
        .rinc     (rinc),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .rlevel   (rlevel)
    );

    assign rempty = (wr_ptr == rd_ptr);

    // Synchronous-read memory model: data valid the cycle after the pop.
    always @(posedge clk) begin
        if (rinc && !rempty) begin
            rdata  <= fmem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (out_valid && out_ready) rx.push_back(out_data);
    end

    initial rdata = 8'h00;

    task automatic push_word(input logic [7:0] w);
        fmem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        r_rst = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rlevel !== 2'd0 || out_data !== 8'h00 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b level=%0d data=%h rinc=%b, want 0 0 00 0",
                     out_valid, rlevel, out_data, rinc);
        end
        r_rst = 1'b0;
    endtask

    task automatic test_empty;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rinc !== 1'b0 || out_valid !== 1'b0 || rlevel !== 2'd0) begin
                errors++;
                $display("FAIL empty[%0d]: rinc=%b valid=%b level=%0d, want 0 0 0",
                         i, rinc, out_valid, rlevel);
            end
        end
    endtask

    task automatic test_first_word;
        logic [7:0] exp [3];
        exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3;
        out_ready = 1'b1;
        rx.delete();
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++;
            $display("FAIL first_rinc: rinc=%b want 1", rinc);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_n1_valid: valid=%b want 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL first_word[%0d]: valid=%b data=%h, want 1 %h",
                         i, out_valid, out_data, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drained: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        pops = 0;
        rx.delete();
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        repeat (5) @(negedge clk);
        checks++;
        if (pops !== 2 || rlevel !== 2'd2 || rinc !== 1'b0 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL bp_full: pops=%0d level=%0d rinc=%b data=%h, want 2 2 0 01",
                     pops, rlevel, rinc, out_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pops !== 2 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: pops=%0d data=%h valid=%b, want 2 01 1",
                     pops, out_data, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("FAIL bp_release[%0d]: valid=%b data=%h, want 1 %h",
                         i, out_valid, out_data, 8'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || rx.size() != 8) begin
            errors++;
            $display("FAIL bp_end: valid=%b rx=%0d, want 0 8", out_valid, rx.size());
        end
    endtask

    task automatic test_toggle;
        int n;
        rx.delete();
        for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i));
        n = 0;
        while (rx.size() < 16 && n < 200) begin
            out_ready = (n % 2 == 0);
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rx.size() != 16) begin
            errors++;
            $display("FAIL toggle_count: got %0d words, want 16", rx.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= rx.size()) begin
                errors++;
                $display("FAIL toggle_word[%0d]: missing, want %h", i, 8'h10 + 8'(i));
            end else if (rx[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL toggle_word[%0d]: got %h want %h", i, rx[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        rx.delete();
        push_word(8'h55); push_word(8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if (rlevel !== 2'd1 || dut.inflight_q !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: level=%0d inflight=%b, want 1 1", rlevel, dut.inflight_q);
        end
        r_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rlevel !== 2'd0 || rinc !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: valid=%b level=%0d rinc=%b data=%h, want 0 0 0 00",
                     out_valid, rlevel, rinc, out_data);
        end
        r_rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rx.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_discard: rx=%0d valid=%b, want 0 0", rx.size(), out_valid);
        end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        pops = 0;
        rx.delete();
        push_word(8'h77);
        repeat (8) @(negedge clk);
        checks++;
        if (pops !== 1 || rinc !== 1'b0 || rempty !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: pops=%0d rinc=%b rempty=%b, want 1 0 1",
                     pops, rinc, rempty);
        end
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h77) begin
            errors++;
            $display("FAIL single_word: count=%0d, want one word 77", rx.size());
        end
    endtask

    initial begin
        test_reset;
        test_empty;
        test_first_word;
        test_backpressure;
        test_toggle;
        test_reset_mid;
        test_single;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
